clk_gen_multi: RTL and testbench
================================

CLK_GEN_MULTI -- requirements
Module: clk_gen_multi

Interface
REQ-001 Parameter NCH, default 4: number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 16: divider counter and ratio width in bits.
REQ-003 Parameter DEFAULT_DIV, default 99: divide value loaded into every channel at reset.
REQ-004 Parameter CH_W, default 2: width of the channel select; must satisfy 2^CH_W >= NCH.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 en  input  NCH  per-channel run enable.
REQ-008 div_wr  input  1  one-cycle divide-value write strobe.
REQ-009 div_ch  input  CH_W  channel index for the write.
REQ-010 div_val  input  CNT_W  new divide value N; the tick period is N+1 cycles.
REQ-011 tick  output  NCH  registered one-cycle clock-enable pulse per channel.
REQ-012 sq  output  NCH  registered square-wave output per channel.
REQ-013 ready  output  NCH  channel has produced at least one tick since its last (re)start.

Function
REQ-014 Each channel i SHALL hold a CNT_W-bit divide register div[i] and a CNT_W-bit counter cnt[i].
REQ-015 With en[i]=1 and no write to channel i, on each edge: if cnt[i]==div[i], then cnt[i]<=0 and tick[i]<=1; otherwise cnt[i]<=cnt[i]+1 and tick[i]<=0.
REQ-016 The tick period SHALL be exactly div[i]+1 cycles. With div[i]=0, tick[i] SHALL stay high continuously from the first edge after enable.
REQ-017 The first tick after en[i] rises SHALL occur div[i]+1 edges after the first edge that samples en[i]=1.
REQ-018 With en[i]=0, on each edge: cnt[i]<=0, tick[i]<=0, sq[i]<=0 and ready[i]<=0. div[i] SHALL be retained.
REQ-019 A write (div_wr=1 and div_ch<NCH) SHALL, on that edge, set div[div_ch]<=div_val, cnt<=0, tick<=0, sq<=0 and ready<=0 for that channel only. The new ratio applies from the next cycle.
REQ-020 A write with div_ch>=NCH SHALL be ignored with no state change.
REQ-021 Write and wrap on the same channel in the same cycle: the write wins and no tick is issued. Other channels are unaffected.
REQ-022 Write while en[i]=0: div[i] SHALL update, and the remaining state stays per REQ-018.
REQ-023 ready[i] SHALL be set on the edge that sets tick[i], and held until disable, write or reset.
REQ-024 Counter comparison SHALL be unsigned equality only. Values are never negative, and no overflow past div[i] can occur.

Reset
REQ-025 While rst=1, asynchronously: cnt=0, div=DEFAULT_DIV, tick=0, sq=0, ready=0 for all channels.
REQ-026 On rst deassertion, channels with en=1 SHALL start counting from 0 at the first edge, per REQ-017.
REQ-027 Reset asserted mid-period SHALL abort the period. No partial tick SHALL be emitted.

Configuration
REQ-028 Macro CLK_GEN_SQUARE_EN: when defined, sq[i] SHALL toggle on every edge that sets tick[i], giving period 2*(div[i]+1) and exactly 50% duty.
REQ-029 When CLK_GEN_SQUARE_EN is undefined, sq SHALL be tied to 0, and no toggle flops SHALL be synthesised. tick and ready are unchanged.

Verification
REQ-030 Reset, then en=4'b0001 with DEFAULT_DIV=99 -> tick[0] pulses at cycles 100, 200, 300 after enable; ready[0] rises with the first pulse; other outputs stay 0.
REQ-031 Write ch1 div_val=0, then en[1]=1 -> tick[1] high every cycle from the first edge. With the macro defined, sq[1] toggles every cycle (period 2).
REQ-032 Write ch2 div_val=3 with en[2]=1, then rewrite ch2 div_val=3 in the exact cycle cnt[2]==3 -> no tick that cycle, and the next tick comes 4 cycles later.
REQ-033 Write div_ch=7 with NCH=4 -> all div, cnt and outputs unchanged, checked against a shadow model.
REQ-034 Run ch0 at div=9, assert rst for 1 cycle at cnt=5 -> all outputs 0 immediately, div[0] returns to 99, and the next tick comes 100 cycles after rst falls.
REQ-035 Build without CLK_GEN_SQUARE_EN and repeat REQ-030 -> sq stays 0, and tick/ready timing is identical.

Source files
------------

// File: rtl/clk_gen_multi_if.sv
// Divide-value write bus for clk_gen_multi.
// Master drives the strobe, channel index and new ratio.
interface clk_gen_multi_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 16
);
    logic             div_wr;
    logic [CH_W-1:0]  div_ch;
    logic [CNT_W-1:0] div_val;

    modport master (
        output div_wr,
        output div_ch,
        output div_val
    );

    modport slave (
        input div_wr,
        input div_ch,
        input div_val
    );
endinterface

// File: rtl/clk_gen_multi.sv
// Multi-channel programmable clock-enable divider with tick/ready per channel.
// Define CLK_GEN_SQUARE_EN to add a 50% duty square-wave output per channel.
module clk_gen_multi #(
    parameter int NCH         = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 99,
    parameter int CH_W        = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    clk_gen_multi_if.slave   cfg,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   sq,
    output logic [NCH-1:0]   ready
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CNT_W-1:0] div_q;
        logic [CNT_W-1:0] cnt_q;
        logic             tick_q;
        logic             rdy_q;
        logic             hit;
        logic             wrap;

        // Indices at or above NCH never match any channel.
        assign hit  = cfg.div_wr && (cfg.div_ch == CH_W'(i));
        assign wrap = (cnt_q == div_q);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                div_q  <= CNT_W'(DEFAULT_DIV);
                cnt_q  <= '0;
                tick_q <= 1'b0;
                rdy_q  <= 1'b0;
            end else if (hit) begin
                div_q  <= cfg.div_val;
                cnt_q  <= '0;
                tick_q <= 1'b0;
                rdy_q  <= 1'b0;
            end else if (!en[i]) begin
                cnt_q  <= '0;
                tick_q <= 1'b0;
                rdy_q  <= 1'b0;
            end else if (wrap) begin
                cnt_q  <= '0;
                tick_q <= 1'b1;
                rdy_q  <= 1'b1;
            end else begin
                cnt_q  <= cnt_q + CNT_W'(1);
                tick_q <= 1'b0;
            end
        end

        assign tick[i]  = tick_q;
        assign ready[i] = rdy_q;

`ifdef CLK_GEN_SQUARE_EN
        logic sq_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sq_q <= 1'b0;
            end else if (hit || !en[i]) begin
                sq_q <= 1'b0;
            end else if (wrap) begin
                sq_q <= ~sq_q;
            end
        end

        assign sq[i] = sq_q;
`else
        assign sq[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_clk_gen_multi.sv
// Scoreboard bench for clk_gen_multi: a spec model predicts
// tick/sq/ready each edge, plus directed timing checks.
module tb_clk_gen_multi;
    localparam int NCH   = 4;
    localparam int CNT_W = 16;
    localparam int CH_W  = 3;
    localparam int DDIV  = 99;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NCH-1:0] en  = '0;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;
    logic [NCH-1:0] ready;

    clk_gen_multi_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg ();

    clk_gen_multi #(
        .NCH(NCH),
        .CNT_W(CNT_W),
        .DEFAULT_DIV(DDIV),
        .CH_W(CH_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .cfg(cfg.slave),
        .tick(tick),
        .sq(sq),
        .ready(ready)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    logic [CNT_W-1:0] m_div [NCH];
    logic [CNT_W-1:0] m_cnt [NCH];
    logic [NCH-1:0]   m_tick;
    logic [NCH-1:0]   m_sq;
    logic [NCH-1:0]   m_ready;
    logic [3*NCH-1:0] sb_q [$];

    task automatic check(input string tag,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_div[i] = CNT_W'(DDIV);
            m_cnt[i] = '0;
        end
        m_tick  = '0;
        m_sq    = '0;
        m_ready = '0;
    endtask

    task automatic m_step();
        if (rst) begin
            m_reset();
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cfg.div_wr && int'(cfg.div_ch) == i) begin
                    m_div[i]   = cfg.div_val;
                    m_cnt[i]   = '0;
                    m_tick[i]  = 1'b0;
                    m_sq[i]    = 1'b0;
                    m_ready[i] = 1'b0;
                end else if (!en[i]) begin
                    m_cnt[i]   = '0;
                    m_tick[i]  = 1'b0;
                    m_sq[i]    = 1'b0;
                    m_ready[i] = 1'b0;
                end else if (m_cnt[i] == m_div[i]) begin
                    m_cnt[i]   = '0;
                    m_tick[i]  = 1'b1;
                    m_ready[i] = 1'b1;
`ifdef CLK_GEN_SQUARE_EN
                    m_sq[i]    = ~m_sq[i];
`endif
                end else begin
                    m_cnt[i]   = m_cnt[i] + CNT_W'(1);
                    m_tick[i]  = 1'b0;
                end
            end
        end
    endtask

    task automatic cyc();
        logic [3*NCH-1:0] e;
        @(posedge clk);
        m_step();
        sb_q.push_back({m_tick, m_sq, m_ready});
        @(negedge clk);
        e = sb_q.pop_front();
        check("sb", {20'd0, tick, sq, ready}, {20'd0, e});
    endtask

    task automatic wr_div(input int ch, input int val);
        cfg.div_wr  = 1'b1;
        cfg.div_ch  = CH_W'(ch);
        cfg.div_val = CNT_W'(val);
        cyc();
        cfg.div_wr  = 1'b0;
    endtask

    int n;
    bit found;
    int f2, f3;

    initial begin
        cfg.div_wr  = 1'b0;
        cfg.div_ch  = '0;
        cfg.div_val = '0;
        m_reset();
        #2 rst = 1'b1;
        #1 check("rst_out", {20'd0, tick, sq, ready}, 32'd0);
        cyc();
        cyc();
        rst = 1'b0;

        en = 4'b0001;
        for (int c = 1; c <= 300; c++) begin
            cyc();
            if (c == 99 || c == 100 || c == 101 || c == 200 || c == 300)
                check($sformatf("t0_c%0d", c), {31'd0, tick[0]},
                      {31'd0, (c % 100) == 0});
            if (c == 99 || c == 100)
                check($sformatf("rdy0_c%0d", c), {31'd0, ready[0]},
                      {31'd0, c >= 100});
            if (c == 300)
                check("others0", {26'd0, tick[3:1], ready[3:1]}, 32'd0);
        end
        en = 4'b0000;
        cyc();
        check("dis", {20'd0, tick, sq, ready}, 32'd0);

        wr_div(1, 0);
        en = 4'b0010;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            check("t1_cont", {31'd0, tick[1]}, 32'd1);
`ifdef CLK_GEN_SQUARE_EN
            check("sq1_tog", {31'd0, sq[1]}, {31'd0, (c % 2) == 1});
`endif
        end

        en = 4'b0100;
        wr_div(2, 3);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_cnt[2] == 3) found = 1;
            else cyc();
        end
        check("cnt2_tmo", {31'd0, found}, 32'd1);
        wr_div(2, 3);
        check("t2_wrwin", {31'd0, tick[2]}, 32'd0);
        found = 0;
        n = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            cyc();
            n++;
            if (tick[2]) found = 1;
        end
        check("t2_found", {31'd0, found}, 32'd1);
        check("t2_gap", n, 4);

        en = 4'b0000;
        cyc();
        wr_div(3, 2);
        cyc();
        en = 4'b1100;
        f2 = 0;
        f3 = 0;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (tick[2] && f2 == 0) f2 = c;
            if (tick[3] && f3 == 0) f3 = c;
        end
        check("t2_retain", f2, 4);
        check("t3_wr_dis", f3, 3);

        en = 4'b0111;
        wr_div(7, 5);
        for (int c = 0; c < 30; c++) cyc();
        check("ign_ready1", {31'd0, ready[1]}, 32'd1);

        en = 4'b0001;
        wr_div(0, 9);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_cnt[0] == 5) found = 1;
            else cyc();
        end
        check("cnt0_tmo", {31'd0, found}, 32'd1);
        rst = 1'b1;
        #1 check("rst_async", {20'd0, tick, sq, ready}, 32'd0);
        m_reset();
        cyc();
        rst = 1'b0;
        found = 0;
        n = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            cyc();
            n++;
            if (tick[0]) found = 1;
        end
        check("rst_found", {31'd0, found}, 32'd1);
        check("rst_gap", n, 100);
        check("rst_rdy", {31'd0, ready[0]}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
